// File: rtl/hazard_pkg.sv
// Shared types for the load-use hazard unit: hazard cause encoding and
// register-index defaults.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;

    typedef logic [REG_AW_DEF-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        HZ_NONE   = 2'd0,
        HZ_FREEZE = 2'd1,
        HZ_LOAD   = 2'd2,
        HZ_FLUSH  = 2'd3
    } hz_cause_e;

endpackage

// File: rtl/hazard_unit_ml_load_tracker.sv
// Age shift register of in-flight loads that left EX but whose data has not
// yet reached the forwarding network; slot 0 is the youngest.
module load_tracker
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int SLOTS  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              new_vld_i,
    input  logic [REG_AW-1:0] new_rd_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    output logic [SLOTS-1:0]  hit_rs1_o,
    output logic [SLOTS-1:0]  hit_rs2_o
);

    logic [SLOTS-1:0]  r_vld;
    logic [REG_AW-1:0] r_rd [SLOTS];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_vld <= '0;
        end else if (en_i) begin
            r_vld[0] <= new_vld_i;
            for (int k = 1; k < SLOTS; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    // Register indices are qualified by r_vld, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            r_rd[0] <= new_rd_i;
            for (int k = 1; k < SLOTS; k++) begin
                r_rd[k] <= r_rd[k-1];
            end
        end
    end

    always_comb begin
        hit_rs1_o = '0;
        hit_rs2_o = '0;
        for (int k = 0; k < SLOTS; k++) begin
            hit_rs1_o[k] = r_vld[k] && (r_rd[k] == rs1_i);
            hit_rs2_o[k] = r_vld[k] && (r_rd[k] == rs2_i);
        end
    end

endmodule

// File: rtl/hazard_unit_ml.sv
// Load-use hazard unit beside ID: resolves freeze / load-use / branch-flush
// priority combinationally and counts load-use stall cycles.
module hazard_unit_ml
    import hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              ex_valid_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              mem_busy_i,
    input  logic              branch_taken_i,
    output logic              pc_write_o,
    output logic              stall_o,
    output logic              noop_o,
    output logic              flush_o,
    output logic              freeze_o,
    output hz_cause_e         cause_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int SLOTS = LOAD_LAT - 1;

    logic              w_ex_load;
    logic              w_trk_hit_rs1;
    logic              w_trk_hit_rs2;
    logic              w_load_hit;
    logic              w_pc_write;
    logic              w_stall;
    logic              w_noop;
    logic              w_flush;
    logic              w_freeze;
    hz_cause_e         w_cause;
    logic [CNT_W-1:0]  r_stall_cnt;

    function automatic logic src_hit(input logic vld, input logic use_r,
                                     input logic [REG_AW-1:0] r,
                                     input logic ex_hit, input logic trk_hit);
        return vld && use_r && (r != '0) && (ex_hit || trk_hit);
    endfunction

    assign w_ex_load = ex_valid_i && ex_memread_i;

    // With LOAD_LAT=1 only the load in EX matters, so no tracker is built.
    generate
        if (SLOTS > 0) begin : g_trk
            logic [SLOTS-1:0] w_hit_rs1;
            logic [SLOTS-1:0] w_hit_rs2;

            load_tracker #(
                .REG_AW (REG_AW),
                .SLOTS  (SLOTS)
            ) u_trk (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .en_i      (!w_freeze),
                .new_vld_i (w_ex_load && (ex_rd_i != '0)),
                .new_rd_i  (ex_rd_i),
                .rs1_i     (id_rs1_i),
                .rs2_i     (id_rs2_i),
                .hit_rs1_o (w_hit_rs1),
                .hit_rs2_o (w_hit_rs2)
            );

            assign w_trk_hit_rs1 = |w_hit_rs1;
            assign w_trk_hit_rs2 = |w_hit_rs2;
        end else begin : g_no_trk
            assign w_trk_hit_rs1 = 1'b0;
            assign w_trk_hit_rs2 = 1'b0;
        end
    endgenerate

    assign w_load_hit =
        src_hit(id_valid_i, id_use_rs1_i, id_rs1_i,
                w_ex_load && (id_rs1_i == ex_rd_i), w_trk_hit_rs1) ||
        src_hit(id_valid_i, id_use_rs2_i, id_rs2_i,
                w_ex_load && (id_rs2_i == ex_rd_i), w_trk_hit_rs2);

    // A branch resolved alongside a load-use hit used stale operands, so the
    // load stall wins and the branch re-resolves once the stall clears.
    always_comb begin
        w_pc_write = 1'b1;
        w_stall    = 1'b0;
        w_noop     = 1'b0;
        w_flush    = 1'b0;
        w_freeze   = 1'b0;
        w_cause    = HZ_NONE;
        if (mem_busy_i) begin
            w_pc_write = 1'b0;
            w_stall    = 1'b1;
            w_freeze   = 1'b1;
            w_cause    = HZ_FREEZE;
        end else if (w_load_hit) begin
            w_pc_write = 1'b0;
            w_stall    = 1'b1;
            w_noop     = 1'b1;
            w_cause    = HZ_LOAD;
        end else if (branch_taken_i) begin
            w_flush    = 1'b1;
            w_cause    = HZ_FLUSH;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if ((w_cause == HZ_LOAD) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign pc_write_o  = w_pc_write;
    assign stall_o     = w_stall;
    assign noop_o      = w_noop;
    assign flush_o     = w_flush;
    assign freeze_o    = w_freeze;
    assign cause_o     = w_cause;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit_ml.sv
// Bench for hazard_unit_ml: four configurations share one stimulus bus; each
// step queues the expected outputs of the instance under test and checks them.
module tb_hazard_unit_ml;

    localparam logic [6:0] C_NONE   = 7'b1000000;
    localparam logic [6:0] C_LOAD   = 7'b0110010;
    localparam logic [6:0] C_FREEZE = 7'b0100101;
    localparam logic [6:0] C_FLUSH  = 7'b1001011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       idv, us1, us2, exv, exm, busy, br;
    logic [4:0] rs1, rs2, exrd;

    logic        pcw [4];
    logic        stl [4];
    logic        nop [4];
    logic        fls [4];
    logic        frz [4];
    logic [1:0]  cse [4];
    logic [15:0] cnt16 [3];
    logic [1:0]  cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         inst;
        logic [6:0] ctl;
        int         cnt;
        string      name;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic       iv;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u1;
        logic       u2;
        logic       ev;
        logic       em;
        logic [4:0] rd;
        logic       bz;
        logic       b;
        logic [6:0] ctl;
    } vec_t;
    vec_t tbl [14];

    always #5 clk = ~clk;

    hazard_unit_ml #(.LOAD_LAT(1), .CNT_W(16)) u_l1 (
        .clk_i(clk), .rst_i(rst_n), .id_valid_i(idv), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_use_rs1_i(us1), .id_use_rs2_i(us2), .ex_valid_i(exv), .ex_memread_i(exm),
        .ex_rd_i(exrd), .mem_busy_i(busy), .branch_taken_i(br), .pc_write_o(pcw[0]),
        .stall_o(stl[0]), .noop_o(nop[0]), .flush_o(fls[0]), .freeze_o(frz[0]),
        .cause_o(cse[0]), .stall_cnt_o(cnt16[0]));

    hazard_unit_ml #(.LOAD_LAT(2), .CNT_W(16)) u_l2 (
        .clk_i(clk), .rst_i(rst_n), .id_valid_i(idv), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_use_rs1_i(us1), .id_use_rs2_i(us2), .ex_valid_i(exv), .ex_memread_i(exm),
        .ex_rd_i(exrd), .mem_busy_i(busy), .branch_taken_i(br), .pc_write_o(pcw[1]),
        .stall_o(stl[1]), .noop_o(nop[1]), .flush_o(fls[1]), .freeze_o(frz[1]),
        .cause_o(cse[1]), .stall_cnt_o(cnt16[1]));

    hazard_unit_ml #(.LOAD_LAT(3), .CNT_W(16)) u_l3 (
        .clk_i(clk), .rst_i(rst_n), .id_valid_i(idv), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_use_rs1_i(us1), .id_use_rs2_i(us2), .ex_valid_i(exv), .ex_memread_i(exm),
        .ex_rd_i(exrd), .mem_busy_i(busy), .branch_taken_i(br), .pc_write_o(pcw[2]),
        .stall_o(stl[2]), .noop_o(nop[2]), .flush_o(fls[2]), .freeze_o(frz[2]),
        .cause_o(cse[2]), .stall_cnt_o(cnt16[2]));

    hazard_unit_ml #(.LOAD_LAT(3), .CNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst_n), .id_valid_i(idv), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_use_rs1_i(us1), .id_use_rs2_i(us2), .ex_valid_i(exv), .ex_memread_i(exm),
        .ex_rd_i(exrd), .mem_busy_i(busy), .branch_taken_i(br), .pc_write_o(pcw[3]),
        .stall_o(stl[3]), .noop_o(nop[3]), .flush_o(fls[3]), .freeze_o(frz[3]),
        .cause_o(cse[3]), .stall_cnt_o(cnt2));

    function automatic logic [6:0] get_ctl(input int i);
        return {pcw[i], stl[i], nop[i], fls[i], frz[i], cse[i]};
    endfunction

    function automatic int get_cnt(input int i);
        if (i < 3) return int'(cnt16[i]);
        return int'(cnt2);
    endfunction

    task automatic drive(input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2, input logic ev, input logic em,
                         input logic [4:0] rd, input logic bz, input logic b);
        idv = iv; rs1 = r1; rs2 = r2; us1 = u1; us2 = u2;
        exv = ev; exm = em; exrd = rd; busy = bz; br = b;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // ID holds add x6,x5,x7; EX holds the given instruction.
    task automatic dep_add(input logic ev, input logic em, input logic [4:0] rd,
                           input logic bz, input logic b);
        drive(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, ev, em, rd, bz, b);
    endtask

    task automatic expect_out(input int inst, input logic [6:0] ctl, input int cnt,
                              input string nm);
        exp_t e;
        e.inst = inst; e.ctl = ctl; e.cnt = cnt; e.name = nm;
        sbq.push_back(e);
    endtask

    // Sample on the falling edge, then move to just after the next rising edge.
    task automatic check();
        exp_t e;
        @(negedge clk);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_checks++;
            if (get_ctl(e.inst) !== e.ctl) begin
                n_fail++;
                $display("FAIL %s ctl inst%0d: got %b want %b", e.name, e.inst,
                         get_ctl(e.inst), e.ctl);
            end
            n_checks++;
            if (get_cnt(e.inst) != e.cnt) begin
                n_fail++;
                $display("FAIL %s cnt inst%0d: got %0d want %0d", e.name, e.inst,
                         get_cnt(e.inst), e.cnt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) expect_out(i, C_NONE, 0, nm);
        check();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_cnt;
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        do_reset("reset");

        // Single-cycle combinational table on LOAD_LAT=1.
        tbl[0]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_NONE};
        tbl[1]  = '{1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, C_LOAD};
        tbl[2]  = '{1'b1, 5'd7, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, C_LOAD};
        tbl[3]  = '{1'b1, 5'd7, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, C_NONE};
        tbl[4]  = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, C_NONE};
        tbl[5]  = '{1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, C_NONE};
        tbl[6]  = '{1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, C_NONE};
        tbl[7]  = '{1'b0, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, C_NONE};
        tbl[8]  = '{1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, C_FLUSH};
        tbl[9]  = '{1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, C_LOAD};
        tbl[10] = '{1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, C_FREEZE};
        tbl[11] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_FREEZE};
        tbl[12] = '{1'b1, 5'd5, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, C_NONE};
        tbl[13] = '{1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, C_LOAD};
        exp_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].iv, tbl[i].r1, tbl[i].r2, tbl[i].u1, tbl[i].u2,
                  tbl[i].ev, tbl[i].em, tbl[i].rd, tbl[i].bz, tbl[i].b);
            expect_out(0, tbl[i].ctl, exp_cnt, $sformatf("tbl%0d", i));
            check();
            if (tbl[i].ctl == C_LOAD) exp_cnt++;
        end

        // LOAD_LAT=1: one stall, hazard beats branch, then branch flushes.
        do_reset("reset_l1");
        dep_add(1'b1, 1'b1, 5'd5, 1'b0, 1'b1); expect_out(0, C_LOAD,  0, "l1_stall"); check();
        dep_add(1'b0, 1'b0, 5'd0, 1'b0, 1'b1); expect_out(0, C_FLUSH, 1, "l1_flush"); check();
        idle();                                expect_out(0, C_NONE,  1, "l1_idle");  check();

        // LOAD_LAT=3: three stalls behind a direct load, one stall two behind.
        do_reset("reset_l3");
        dep_add(1'b1, 1'b1, 5'd5, 1'b0, 1'b0); expect_out(2, C_LOAD, 0, "l3_s0"); check();
        dep_add(1'b0, 1'b0, 5'd0, 1'b0, 1'b0); expect_out(2, C_LOAD, 1, "l3_s1"); check();
        dep_add(1'b0, 1'b0, 5'd0, 1'b0, 1'b0); expect_out(2, C_LOAD, 2, "l3_s2"); check();
        dep_add(1'b0, 1'b0, 5'd0, 1'b0, 1'b0); expect_out(2, C_NONE, 3, "l3_rel"); check();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        expect_out(2, C_NONE, 3, "l3_ld"); check();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0);
        expect_out(2, C_NONE, 3, "l3_gap"); check();
        dep_add(1'b1, 1'b0, 5'd10, 1'b0, 1'b0); expect_out(2, C_LOAD, 3, "l3_far"); check();
        dep_add(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);  expect_out(2, C_NONE, 4, "l3_far_rel"); check();

        // Async reset mid-stall clears tracker and counter at once.
        dep_add(1'b1, 1'b1, 5'd5, 1'b0, 1'b0); expect_out(2, C_LOAD, 4, "rst_s0"); check();
        dep_add(1'b0, 1'b0, 5'd0, 1'b0, 1'b0); expect_out(2, C_LOAD, 5, "rst_s1"); check();
        rst_n = 1'b0;
        dep_add(1'b0, 1'b0, 5'd0, 1'b0, 1'b0); expect_out(2, C_NONE, 0, "rst_mid"); check();
        idle();                                expect_out(2, C_NONE, 0, "rst_idle"); check();
        rst_n = 1'b1;
        dep_add(1'b0, 1'b0, 5'd0, 1'b0, 1'b0); expect_out(2, C_NONE, 0, "rst_after"); check();

        // LOAD_LAT=2: memory busy for 4 cycles in the middle of a stall.
        do_reset("reset_l2");
        dep_add(1'b1, 1'b1, 5'd5, 1'b0, 1'b0); expect_out(1, C_LOAD, 0, "frz_s0"); check();
        for (int i = 0; i < 4; i++) begin
            dep_add(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
            expect_out(1, C_FREEZE, 1, $sformatf("frz_%0d", i));
            check();
        end
        dep_add(1'b0, 1'b0, 5'd0, 1'b0, 1'b0); expect_out(1, C_LOAD, 1, "frz_s1"); check();
        dep_add(1'b0, 1'b0, 5'd0, 1'b0, 1'b0); expect_out(1, C_NONE, 2, "frz_rel"); check();

        // CNT_W=2 counter saturates at 3.
        do_reset("reset_sat");
        for (int i = 0; i < 5; i++) begin
            dep_add(1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
            expect_out(3, C_LOAD, (i < 3) ? i : 3, $sformatf("sat_%0d", i));
            check();
        end
        idle(); expect_out(3, C_NONE, 3, "sat_end"); check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit_ml.md
# hazard_unit_ml

Parametrised load-use hazard unit for the 5-stage RISC-V pipeline. It supports data memories whose load result reaches the forwarding network `LOAD_LAT` cycles after the load leaves EX. It sits beside the ID stage and drives PC write-enable, IF/ID hold, ID/EX bubble insertion, IF/ID flush and a global pipeline freeze. It also tracks in-flight loads in a small age shift register and counts load-use stall cycles for performance reporting.

## Interface
- `REG_AW`, 5: register-index width.
- `LOAD_LAT`, 1: cycles of load-use separation required. Must be ≥1; 1 means only the load in EX is checked.
- `CNT_W`, 16: width of the stall-cycle counter.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset; asynchronous, active-low.
- `id_valid_i` in 1: ID holds a valid instruction.
- `id_rs1_i`, `id_rs2_i` in REG_AW: ID source registers.
- `id_use_rs1_i`, `id_use_rs2_i` in 1: ID instruction actually reads rs1/rs2.
- `ex_valid_i` in 1: EX holds a valid (non-bubble) instruction.
- `ex_memread_i` in 1: EX instruction is a load.
- `ex_rd_i` in REG_AW: EX destination register.
- `mem_busy_i` in 1: data memory not ready; whole pipeline must freeze.
- `branch_taken_i` in 1: branch resolved taken in ID.
- `pc_write_o` out 1: PC update enable.
- `stall_o` out 1: hold IF/ID.
- `noop_o` out 1: zero the ID/EX control fields (bubble).
- `flush_o` out 1: clear IF/ID.
- `freeze_o` out 1: hold ID/EX, EX/MEM and MEM/WB.
- `cause_o` out 2: current hazard cause (package enum).
- `stall_cnt_o` out CNT_W: saturating count of load-use stall cycles.

## Operation
- Source match: `src_hit(r)` requires `id_valid_i`, the matching `id_use_*` bit, and r≠0. A hit occurs when r equals `ex_rd_i` while `ex_valid_i & ex_memread_i`, or when r equals the rd of any valid tracker slot.
- Tracker: LOAD_LAT-1 slots of {valid, rd}, slot 0 youngest. Updates only when `freeze_o`=0:
  - slot[0] ← {ex_valid_i & ex_memread_i & ex_rd_i≠0, ex_rd_i}.
  - slot[k] ← slot[k-1]; the oldest slot drops off.
  - Holds all slots while frozen.
  - Absent when LOAD_LAT=1.
- Priority, evaluated combinationally each cycle:
  - FREEZE (`mem_busy_i`): pc_write=0, stall=1, freeze=1, noop=0, flush=0.
  - LOAD (any `src_hit`, no freeze): pc_write=0, stall=1, noop=1, freeze=0, flush=0. A simultaneous `branch_taken_i` is ignored, because its operands are stale; the branch re-resolves after the stall.
  - FLUSH (`branch_taken_i` only): flush=1, pc_write=1, other outputs 0.
  - NONE: pc_write=1, all other outputs 0.
- `cause_o` reports the winning case.
- `stall_cnt_o`: +1 on each clock edge where cause=LOAD; saturates at all-ones; unchanged under FREEZE.

## Timing
- All control outputs are combinational from inputs and tracker state; zero-cycle latency.
- A dependent instruction waits exactly LOAD_LAT stall cycles behind a load directly ahead of it, plus any freeze cycles.
- Freeze mid-stall extends the stall without advancing the tracker and without counting those cycles.
- Reset (async assert, any cycle): all tracker slots invalid, `stall_cnt_o`=0.
  - Outputs then depend on inputs only. With idle inputs: pc_write_o=1, all others 0, cause=NONE.
- Reset deassertion takes effect at the next rising edge; no partial tracker state survives.
- A bubble inserted by `noop_o` arrives at EX with `ex_valid_i`=0 and is never tracked.

## Structure
- `hazard_pkg`:
  - `hz_cause_e` {HZ_NONE=0, HZ_FREEZE=1, HZ_LOAD=2, HZ_FLUSH=3}.
  - REG_AW default.
  - `reg_idx_t`.
- Sub-module `load_tracker`:
  - Parametrised shift register of LOAD_LAT-1 slots.
  - Inputs: enable and the new entry.
  - Exports a per-slot hit vector for rs1 and rs2.
  - Generate-guarded so LOAD_LAT=1 yields no flops.
- Top level holds the priority logic and the counter.

## Test plan
- LOAD_LAT=1, EX `lw x5`, ID `add x6,x5,x7` (use_rs1=1) -> one cycle with pc_write=0, stall=1, noop=1, cause=2. Next cycle (EX bubble) pc_write=1. stall_cnt=1.
- LOAD_LAT=3, `lw x5`, then dependent `add` -> 3 consecutive LOAD cycles, then release; stall_cnt=3. Same load with the dependent instruction two slots behind -> 1 stall cycle.
- Load to x0, or `id_use_rs2_i`=0 with rs2 matching -> no stall.
- LOAD_LAT=2, mem_busy=1 for 4 cycles during a load-use stall -> FREEZE outputs for 4 cycles, tracker frozen, counter frozen, then the remaining stall cycle occurs.
- Hazard and branch_taken in the same cycle -> flush=0, stall=1. After release, branch_taken alone -> flush=1, pc_write=1.
- Async reset asserted mid-stall with LOAD_LAT=3 -> tracker cleared and stall_cnt=0 immediately; idle outputs pc_write=1. Counter saturation checked with CNT_W=2: 5 stall cycles -> 3.
